uart_rx_controller: RTL and testbench
=====================================

# uart_rx_controller

Receive-side sequencing controller for the UART that feeds characters to the NIOS II processor. It tracks the serial line on a 16x oversample tick and detects the start bit. It then times the per-bit sample point, counts the 10-bit frame (start, 8 data, stop) and assembles the data byte. It holds the character in a ready register with a read-acknowledge handshake, and flags framing and overrun errors.

## Interface
Parameters:
- OVERSAMPLE, default 16: sampleTick pulses per bit period; must be even and at least 4.
- DATA_BITS, default 8: data bits per frame, sent LSB first.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- rst  input  1  reset; synchronous and active-low.
- sampleTick  input  1  one-clk pulse at OVERSAMPLE x baud, from the baud generator.
- serialIn  input  1  receive line, already synchronized to clk; idles high.
- readAck  input  1  one-clk pulse when the NIOS II reads rxData.
- rxData  output  DATA_BITS  last received character.
- dataReady  output  1  level signal; rxData holds an unread character.
- charReceived  output  1  one-clk pulse when a frame completes.
- framingError  output  1  sticky flag; the stop bit of the last frame sampled 0.
- overrun  output  1  sticky flag; a frame completed while dataReady=1 and no readAck arrived in that cycle.
- busy  output  1  high whenever state != IDLE.

## Operation
- State machine states: IDLE, START, DATA, STOP.
- Internal counters:
  - sampleCnt, width clog2(OVERSAMPLE).
  - bitCnt, width clog2(DATA_BITS).
  - shift register, DATA_BITS wide.
  - armed flag.
- serialIn is examined only on cycles with sampleTick=1. Without a tick, the state machine and counters hold. readAck is processed on every clk regardless of ticks.
- IDLE:
  - armed is set on any tick with serialIn=1.
  - A tick with armed=1 and serialIn=0 is the detection tick: go to START, sampleCnt=1, armed=0.
- START: each tick increments sampleCnt. On the tick where sampleCnt reaches OVERSAMPLE/2 (mid start bit):
  - serialIn=0: go to DATA, sampleCnt=0, bitCnt=0.
  - serialIn=1 (glitch): go to IDLE with no outputs changed.
- DATA:
  - Each tick increments sampleCnt.
  - On the tick where sampleCnt reaches OVERSAMPLE-1: shift serialIn into the shift register MSB with a right shift (LSB-first assembly), set sampleCnt=0, increment bitCnt.
  - After the DATA_BITS-th sample, go to STOP.
- STOP: on the tick where sampleCnt reaches OVERSAMPLE-1, sample the stop bit, complete the frame and go to IDLE. Completion does all of the following in the same edge:
  - rxData <= shift register.
  - dataReady <= 1.
  - charReceived <= 1 for one clk.
  - framingError <= ~serialIn. The frame is delivered even when the stop bit is bad.
  - overrun <= overrun | (dataReady & ~readAck).
- readAck without a simultaneous completion: clears dataReady, framingError and overrun. readAck while dataReady=0 has no effect.
- readAck in the same cycle as a completion:
  - The new character is loaded and dataReady stays 1.
  - overrun is not set.
  - framingError reflects only the new frame.
- Line held low (break): produces one frame with rxData=0 and framingError=1. armed stays 0 until serialIn=1 is seen, so no further frames start.
- Reset: all outputs, counters and the shift register go to 0, state goes to IDLE, armed=0. Reset wins over every other event, including mid-frame. The receiver re-arms on the first tick with serialIn high.

## Timing
- Start validation happens on tick OVERSAMPLE/2 after the detection tick (tick 8).
- Data bit n (n = 0..DATA_BITS-1) is sampled on tick OVERSAMPLE/2 + OVERSAMPLE*(n+1) after detection.
- The stop bit is sampled on tick OVERSAMPLE/2 + OVERSAMPLE*(DATA_BITS+1) = 152 with default parameters.
- rxData, dataReady, charReceived and framingError update at the clk edge of that stop-sample tick and are visible the following cycle. charReceived is high for exactly one clk.
- readAck takes effect at the next edge; dataReady reads 0 one cycle after the readAck pulse.
- busy rises the cycle after the detection tick and falls the cycle after the stop-sample tick or the glitch-reject tick.
- Reset-value table: all outputs 0.

## Test plan
- Reset: hold rst=0 for 3 clks with serialIn toggling -> all outputs 0, busy 0. Release rst -> no frame starts before serialIn has been seen high on a tick.
- Good frame 0xA5, stop=1, sampleTick every 4 clks -> on tick 152: rxData=0xA5, dataReady=1, one-clk charReceived, framingError=0, overrun=0. readAck -> dataReady=0 next cycle.
- Glitch: serialIn low for 4 ticks then high -> START rejected at tick 8, busy returns 0, dataReady stays 0, rxData unchanged.
- Framing error: frame 0x3C with stop=0, then line held low for 40 bit times -> rxData=0x3C, framingError=1, exactly one charReceived. Line returns high, then frame 0x81 -> rxData=0x81, framingError=0.
- Overrun: frames 0x11 then 0x22 with no readAck -> rxData=0x22, overrun=1. readAck clears dataReady and overrun. Repeat with readAck coincident with the 0x22 completion edge -> dataReady=1, overrun=0.
- Reset mid-frame: assert rst after data bit 4 -> busy=0 and all outputs 0 next cycle. Line idles high, then frame 0x5A -> rxData=0x5A received correctly.

Source files
------------

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: 16x-oversampled start detect, mid-bit sampling, LSB-first byte assembly.
// Frame delivered on the stop-sample tick edge; no backpressure, unread characters flag overrun.
module uart_rx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sampleTick,
    input  logic                 serialIn,
    input  logic                 readAck,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 dataReady,
    output logic                 charReceived,
    output logic                 framingError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF     = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        sample_cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic                 armed, armed_nxt;
    logic                 complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            armed      <= 1'b0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
            bit_cnt    <= bit_nxt;
            shift_reg  <= shift_nxt;
            armed      <= armed_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = sample_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_reg;
        armed_nxt = armed;
        complete  = 1'b0;
        if (sampleTick) begin
            case (state)
                IDLE: begin
                    // Arming on a high tick keeps a held-low line from retriggering.
                    if (serialIn) begin
                        armed_nxt = 1'b1;
                    end else if (armed) begin
                        state_nxt = START;
                        cnt_nxt   = CW'(1);
                        armed_nxt = 1'b0;
                    end
                end
                START: begin
                    if (sample_cnt == HALF) begin
                        cnt_nxt = '0;
                        if (!serialIn) begin
                            state_nxt = DATA;
                            bit_nxt   = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = sample_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (sample_cnt == LAST) begin
                        shift_nxt = {serialIn, shift_reg[DATA_BITS-1:1]};
                        cnt_nxt   = '0;
                        bit_nxt   = bit_cnt + BW'(1);
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end
                    end else begin
                        cnt_nxt = sample_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (sample_cnt == LAST) begin
                        complete  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = sample_cnt + CW'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxData       <= '0;
            dataReady    <= 1'b0;
            charReceived <= 1'b0;
            framingError <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            charReceived <= complete;
            if (complete) begin
                // A coincident read consumes the old character, so it does not overrun.
                rxData       <= shift_reg;
                dataReady    <= 1'b1;
                framingError <= ~serialIn;
                overrun      <= overrun | (dataReady & ~readAck);
            end else if (readAck && dataReady) begin
                dataReady    <= 1'b0;
                framingError <= 1'b0;
                overrun      <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Randomized-tick UART frames against a frame-level model; a scoreboard checks each delivered character.
module tb_uart_rx_controller;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sampleTick = 1'b0;
    logic          serialIn = 1'b1;
    logic          readAck = 1'b0;
    logic [DB-1:0] rxData;
    logic          dataReady, charReceived, framingError, overrun, busy;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned busy_cyc = 0;

    typedef struct {
        logic [DB-1:0] data;
        logic          fe;
        logic          ovr;
        int unsigned   cyc;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    logic m_unread = 1'b0;
    logic m_ovr = 1'b0;

    uart_rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .sampleTick(sampleTick), .serialIn(serialIn),
        .readAck(readAck), .rxData(rxData), .dataReady(dataReady),
        .charReceived(charReceived), .framingError(framingError),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every charReceived pulse must match the oldest expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (charReceived) begin
                check("frame expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rxData", 32'(rxData), 32'(e.data));
                    check("framingError", 32'(framingError), 32'(e.fe));
                    check("overrun", 32'(overrun), 32'(e.ovr));
                    check("dataReady on completion", 32'(dataReady), 1);
                    check("completion latency", cyc, e.cyc + 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick_at(input logic lvl, input logic ack, input logic mark);
        @(negedge clk);
        serialIn   = lvl;
        sampleTick = 1'b1;
        readAck    = ack;
        if (mark) begin
            pend.cyc = cyc;
            sb.push_back(pend);
        end
        @(negedge clk);
        sampleTick = 1'b0;
        readAck    = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_at(1'b1, 1'b0, 1'b0);
    endtask

    // One full frame; the stop bit is sampled on its middle tick, OS/2 ticks into it.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic ack);
        pend.data = d;
        pend.fe   = ~stop;
        pend.ovr  = m_ovr | (m_unread & ~ack);
        m_ovr     = pend.ovr;
        m_unread  = 1'b1;
        for (int i = 0; i < OS; i++) tick_at(1'b0, 1'b0, 1'b0);
        for (int b = 0; b < DB; b++)
            for (int i = 0; i < OS; i++) tick_at(d[b], 1'b0, 1'b0);
        for (int i = 0; i < OS; i++) tick_at(stop, ack && (i == OS / 2), i == OS / 2);
    endtask

    task automatic do_ack();
        @(negedge clk);
        readAck = 1'b1;
        @(negedge clk);
        readAck = 1'b0;
        m_unread = 1'b0;
        m_ovr    = 1'b0;
        check("dataReady after ack", 32'(dataReady), 32'(m_unread));
        check("overrun after ack", 32'(overrun), 32'(m_ovr));
        check("framingError after ack", 32'(framingError), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rxData"}, 32'(rxData), 0);
        check({tag, " dataReady"}, 32'(dataReady), 0);
        check({tag, " charReceived"}, 32'(charReceived), 0);
        check({tag, " framingError"}, 32'(framingError), 0);
        check({tag, " overrun"}, 32'(overrun), 0);
        check({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        int unsigned b0;
        logic [DB-1:0] d;
        logic stop, ack;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            serialIn   = i[0];
            sampleTick = 1'b1;
        end
        @(negedge clk);
        sampleTick = 1'b0;
        check_all_zero("reset");

        // Line low straight out of reset must not start a frame.
        rst      = 1'b1;
        serialIn = 1'b0;
        b0 = busy_cyc;
        for (int i = 0; i < 20; i++) tick_at(1'b0, 1'b0, 1'b0);
        check("no start before idle high", busy_cyc - b0, 0);

        idle(5);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(2);
        check("A5 held", 32'(rxData), 32'h0A5);
        do_ack();

        // Glitch: 4 low ticks then high, rejected at the mid-start check.
        idle(3);
        b0 = busy_cyc;
        for (int i = 0; i < 4; i++) tick_at(1'b0, 1'b0, 1'b0);
        idle(20);
        check("glitch started", 32'(busy_cyc > b0), 1);
        check("glitch busy back", 32'(busy), 0);
        check("glitch dataReady", 32'(dataReady), 0);
        check("glitch rxData", 32'(rxData), 32'h0A5);

        // Bad stop bit followed by a long break: exactly one frame.
        idle(3);
        send_frame(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 40 * OS; i++) tick_at(1'b0, 1'b0, 1'b0);
        check("break fe", 32'(framingError), 1);
        check("break rxData", 32'(rxData), 32'h03C);
        check("break busy", 32'(busy), 0);
        idle(4);
        do_ack();
        send_frame(8'h81, 1'b1, 1'b0);
        idle(2);
        check("81 fe", 32'(framingError), 0);
        do_ack();

        // Overrun, then the same pair with a read coincident with completion.
        idle(2);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(2);
        check("overrun set", 32'(overrun), 1);
        do_ack();
        idle(2);
        send_frame(8'h11, 1'b1, 1'b0);
        idle(2);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(2);
        check("coincident ack dataReady", 32'(dataReady), 1);
        check("coincident ack overrun", 32'(overrun), 0);
        do_ack();

        // Reset after data bit 4 of a frame.
        idle(2);
        d = 8'h5A;
        for (int i = 0; i < OS; i++) tick_at(1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++)
            for (int i = 0; i < OS; i++) tick_at(d[b], 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_all_zero("mid-frame reset");
        m_unread = 1'b0;
        m_ovr    = 1'b0;
        idle(3);
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2);
        do_ack();

        for (int n = 0; n < 8; n++) begin
            idle($urandom_range(1, 10));
            d    = DB'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            ack  = ($urandom_range(0, 3) == 0);
            send_frame(d, stop, ack);
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        repeat (10) @(negedge clk);
        check("scoreboard drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
